// File: rtl/sv32_pkg.sv
// Shared Sv32 walker types: PTE layout, the TLB update beat and the walker state encoding.
package sv32_pkg;

  localparam int PPN_W      = 22;
  localparam int VPN_W      = 20;
  localparam int VPN_LVL_W  = 10;
  localparam int ASID_UPD_W = 9;
  localparam int PTE_W      = 32;

  typedef struct packed {
    logic [11:0] ppn1;
    logic [9:0]  ppn0;
    logic [1:0]  rsw;
    logic        d;
    logic        a;
    logic        g;
    logic        u;
    logic        x;
    logic        w;
    logic        r;
    logic        v;
  } pte_t;

  // Bit layout matches the TLB's update_i port.
  typedef struct packed {
    logic                  valid;
    logic                  is_4m;
    logic [VPN_W-1:0]      vpn;
    logic [ASID_UPD_W-1:0] asid;
    logic [PTE_W-1:0]      pte;
  } tlb_update_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_L1_REQ,
    S_L1_WAIT,
    S_L0_REQ,
    S_L0_WAIT,
    S_UPDATE,
    S_FAULT,
    S_DRAIN
  } state_e;

endpackage

// File: rtl/sv32_ptw_lite_if.sv
// Miss, memory and result signals of the Sv32 walker; master is the walker side.
interface sv32_ptw_lite_if
  import sv32_pkg::*;
#(
  parameter int ASID_WIDTH  = 1,
  parameter int PADDR_WIDTH = 34
);
  logic                   flush_i;
  logic [PPN_W-1:0]       satp_ppn_i;
  logic                   miss_valid_i;
  logic                   miss_ready_o;
  logic [31:0]            miss_vaddr_i;
  logic [ASID_WIDTH-1:0]  miss_asid_i;
  logic                   mem_req_valid_o;
  logic                   mem_req_ready_i;
  logic [PADDR_WIDTH-1:0] mem_req_addr_o;
  logic                   mem_rsp_valid_i;
  logic [PTE_W-1:0]       mem_rsp_data_i;
  logic [62:0]            update_o;
  logic                   fault_valid_o;
  logic [31:0]            fault_vaddr_o;
  logic                   busy_o;

  modport master (
    input  flush_i, satp_ppn_i, miss_valid_i, miss_vaddr_i, miss_asid_i,
           mem_req_ready_i, mem_rsp_valid_i, mem_rsp_data_i,
    output miss_ready_o, mem_req_valid_o, mem_req_addr_o, update_o,
           fault_valid_o, fault_vaddr_o, busy_o
  );

  modport slave (
    output flush_i, satp_ppn_i, miss_valid_i, miss_vaddr_i, miss_asid_i,
           mem_req_ready_i, mem_rsp_valid_i, mem_rsp_data_i,
    input  miss_ready_o, mem_req_valid_o, mem_req_addr_o, update_o,
           fault_valid_o, fault_vaddr_o, busy_o
  );

endinterface

// File: rtl/sv32_pte_check.sv
// Combinational PTE classification for one walk level (level_1 = root level).
module sv32_pte_check
  import sv32_pkg::*;
(
  input  pte_t pte,
  input  logic level_1,
  output logic fault,
  output logic leaf,
  output logic is_4m
);

  logic invalid;
  logic unused_pte;

  assign unused_pte = ^{pte.ppn1, pte.rsw, pte.d, pte.a, pte.g, pte.u};

  // Write-only encodings are reserved and treated like an invalid entry.
  assign invalid = !pte.v || (!pte.r && pte.w);
  assign leaf    = !invalid && (pte.r || pte.x);
  assign is_4m   = leaf && level_1;
  assign fault   = invalid
                 || (leaf && level_1 && (pte.ppn0 != '0))
                 || (!leaf && !level_1);

endmodule

// File: rtl/sv32_ptw_lite.sv
// Two-level Sv32 page-table walker feeding a single update beat (or fault pulse) per TLB miss.
module sv32_ptw_lite
  import sv32_pkg::*;
#(
  parameter int ASID_WIDTH  = 1,
  parameter int PADDR_WIDTH = 34
) (
  input logic             clk_i,
  input logic             rst_i,
  sv32_ptw_lite_if.master bus
);

  state_e                state, state_nxt;
  logic [31:0]           vaddr_q;
  logic [ASID_WIDTH-1:0] asid_q;
  logic [PTE_W-1:0]      pte_q;
  logic                  is_4m_q;

  logic                  accept;
  logic                  req_hs;
  logic                  in_wait;
  logic                  chk_fault, chk_leaf, chk_is_4m;
  pte_t                  rsp_pte;
  logic [PPN_W-1:0]      walk_base;
  logic [VPN_LVL_W-1:0]  walk_idx;
  tlb_update_t           upd;

  assign accept  = bus.miss_valid_i && bus.miss_ready_o;
  assign req_hs  = bus.mem_req_valid_o && bus.mem_req_ready_i;
  assign in_wait = (state == S_L1_WAIT) || (state == S_L0_WAIT);
  assign rsp_pte = pte_t'(bus.mem_rsp_data_i);

  sv32_pte_check u_pte_check (
    .pte     (rsp_pte),
    .level_1 (state == S_L1_WAIT),
    .fault   (chk_fault),
    .leaf    (chk_leaf),
    .is_4m   (chk_is_4m)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Walk context is qualified by state, so it needs no reset.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      vaddr_q <= bus.miss_vaddr_i;
      asid_q  <= bus.miss_asid_i;
    end
    if (in_wait && bus.mem_rsp_valid_i) begin
      pte_q   <= bus.mem_rsp_data_i;
      is_4m_q <= chk_is_4m;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (accept) state_nxt = S_L1_REQ;
      end
      S_L1_REQ, S_L0_REQ: begin
        // An accepted request still owes a response, so a flush must drain it.
        if (req_hs) begin
          if (bus.flush_i)              state_nxt = S_DRAIN;
          else if (state == S_L1_REQ)   state_nxt = S_L1_WAIT;
          else                          state_nxt = S_L0_WAIT;
        end else if (bus.flush_i) begin
          state_nxt = S_IDLE;
        end
      end
      S_L1_WAIT, S_L0_WAIT: begin
        if (bus.flush_i) begin
          state_nxt = bus.mem_rsp_valid_i ? S_IDLE : S_DRAIN;
        end else if (bus.mem_rsp_valid_i) begin
          if (chk_fault)      state_nxt = S_FAULT;
          else if (chk_leaf)  state_nxt = S_UPDATE;
          else                state_nxt = S_L0_REQ;
        end
      end
      S_UPDATE, S_FAULT: state_nxt = S_IDLE;
      S_DRAIN: begin
        if (bus.mem_rsp_valid_i) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign walk_base = (state == S_L0_REQ) ? pte_q[31:10]   : bus.satp_ppn_i;
  assign walk_idx  = (state == S_L0_REQ) ? vaddr_q[21:12] : vaddr_q[31:22];

  assign upd = '{valid: 1'b1,
                 is_4m: is_4m_q,
                 vpn:   vaddr_q[31:12],
                 asid:  ASID_UPD_W'(asid_q),
                 pte:   pte_q};

  assign bus.miss_ready_o    = (state == S_IDLE) && !bus.flush_i;
  assign bus.mem_req_valid_o = (state == S_L1_REQ) || (state == S_L0_REQ);
  assign bus.mem_req_addr_o  = bus.mem_req_valid_o
                             ? (PADDR_WIDTH'({walk_base, 12'h000}) + PADDR_WIDTH'({walk_idx, 2'b00}))
                             : '0;
  assign bus.update_o        = ((state == S_UPDATE) && !bus.flush_i) ? upd : '0;
  assign bus.fault_valid_o   = (state == S_FAULT) && !bus.flush_i;
  assign bus.fault_vaddr_o   = bus.fault_valid_o ? vaddr_q : '0;
  assign bus.busy_o          = (state != S_IDLE);

endmodule

// File: tb/tb_sv32_ptw_lite.sv
// Directed bench for sv32_ptw_lite: a table-walk reference model plus protocol rules checked every cycle.
module tb_sv32_ptw_lite;

  logic clk;
  logic rst;

  sv32_ptw_lite_if #(.ASID_WIDTH(1), .PADDR_WIDTH(34)) bus ();

  sv32_ptw_lite #(.ASID_WIDTH(1), .PADDR_WIDTH(34)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [logic [33:0]];
  logic [33:0] exp_addr[$];
  logic [62:0] exp_upd[$];
  logic [31:0] exp_fault[$];
  logic [33:0] lit_addr[$];
  logic [62:0] lit_upd[$];
  logic [31:0] lit_fault[$];

  int rsp_lat = 1;
  int exp_lat = 0;
  logic done = 1'b0;
  logic fin  = 1'b0;

  function automatic void chk(string nm, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endfunction

  function automatic logic [31:0] mem_rd(logic [33:0] a);
    return mem.exists(a) ? mem[a] : 32'h0;
  endfunction

  function automatic logic pte_bad(logic [31:0] p);
    return !p[0] || (!p[1] && p[2]);
  endfunction

  // Reference walk: derives request addresses and the outcome straight from the table in mem.
  function automatic void model_walk(logic [21:0] satp, logic [31:0] va, logic asid);
    logic [33:0] a;
    logic [31:0] p;
    logic [8:0]  as9;
    as9 = {8'h00, asid};
    a = {satp, 12'h000} + {22'h0, va[31:22], 2'b00};
    exp_addr.push_back(a);
    p = mem_rd(a);
    if (pte_bad(p)) begin
      exp_fault.push_back(va);
      return;
    end
    if (p[1] || p[3]) begin
      if (p[19:10] != 10'h0) exp_fault.push_back(va);
      else                   exp_upd.push_back({1'b1, 1'b1, va[31:12], as9, p});
      return;
    end
    a = {p[31:10], 12'h000} + {22'h0, va[21:12], 2'b00};
    exp_addr.push_back(a);
    p = mem_rd(a);
    if (pte_bad(p) || !(p[1] || p[3])) exp_fault.push_back(va);
    else                               exp_upd.push_back({1'b1, 1'b0, va[31:12], as9, p});
  endfunction

  // Memory responder: fixed latency of rsp_lat cycles after each request handshake.
  logic        r_hs;
  logic [33:0] r_ha;
  logic [33:0] r_pa;
  int          r_pend;

  initial begin
    bus.mem_rsp_valid_i = 1'b0;
    bus.mem_rsp_data_i  = 32'h0;
    r_pend = 0;
    r_pa   = '0;
    forever begin
      @(negedge clk);
      r_hs = bus.mem_req_valid_o && bus.mem_req_ready_i && !rst;
      r_ha = bus.mem_req_addr_o;
      @(posedge clk);
      #1;
      bus.mem_rsp_valid_i = 1'b0;
      bus.mem_rsp_data_i  = 32'h0;
      if (r_pend > 0) begin
        r_pend--;
        if (r_pend == 0) begin
          bus.mem_rsp_valid_i = 1'b1;
          bus.mem_rsp_data_i  = mem_rd(r_pa);
        end
      end
      if (r_hs) begin
        r_pa   = r_ha;
        r_pend = rsp_lat - 1;
        if (r_pend == 0) begin
          bus.mem_rsp_valid_i = 1'b1;
          bus.mem_rsp_data_i  = mem_rd(r_pa);
        end
      end
    end
  end

  // Compare process
  int          cyc = 0;
  int          acc_cyc = 0;
  int          busy_cnt = 0;
  int          miss_cnt = 0;
  logic        rst_q = 1'b0;
  logic        m_hs;
  logic        outstanding = 1'b0, flushed = 1'b0;
  logic        p_idle = 1'b0, p_acc = 1'b0, p_drop = 1'b0, p_drain = 1'b0, p_stall = 1'b0;
  logic [33:0] p_addr = '0;

  always @(negedge clk) begin
    cyc++;
    if (rst_q) begin
      chk("rst_ctrl", 64'({bus.miss_ready_o, bus.mem_req_valid_o, bus.fault_valid_o, bus.busy_o}), 64'(4'b1000));
      chk("rst_update", 64'(bus.update_o), 64'(0));
      chk("rst_req_addr", 64'(bus.mem_req_addr_o), 64'(0));
      chk("rst_fault_vaddr", 64'(bus.fault_vaddr_o), 64'(0));
    end
    if (rst) begin
      outstanding = 1'b0; flushed = 1'b0;
      p_idle = 1'b0; p_acc = 1'b0; p_drop = 1'b0; p_drain = 1'b0; p_stall = 1'b0;
      busy_cnt = 0; miss_cnt = 0;
    end else begin
      m_hs = bus.mem_req_valid_o && bus.mem_req_ready_i;
      chk("miss_ready", 64'(bus.miss_ready_o), 64'(!bus.busy_o && !bus.flush_i));
      if (p_idle)      chk("stay_idle", 64'(bus.busy_o), 64'(0));
      if (p_acc)       chk("req_after_accept", 64'({bus.busy_o, bus.mem_req_valid_o}), 64'(2'b11));
      if (p_drop)      chk("flush_drop", 64'({bus.busy_o, bus.mem_req_valid_o}), 64'(0));
      if (p_drain)     chk("drain_end", 64'(bus.busy_o), 64'(0));
      if (p_stall)     chk("req_stable", 64'({bus.mem_req_valid_o, bus.mem_req_addr_o}), 64'({1'b1, p_addr}));
      if (outstanding) chk("busy_outstanding", 64'(bus.busy_o), 64'(1));

      if (m_hs) begin
        if (exp_addr.size() == 0) chk("req_unexpected", 64'(bus.mem_req_addr_o), 64'(0));
        else                      chk("req_addr", 64'(bus.mem_req_addr_o), 64'(exp_addr.pop_front()));
        if (lit_addr.size() != 0) chk("req_addr_lit", 64'(bus.mem_req_addr_o), 64'(lit_addr.pop_front()));
      end
      if (bus.update_o != 63'h0) begin
        if (exp_upd.size() == 0) chk("update_unexpected", 64'(bus.update_o), 64'(0));
        else                     chk("update", 64'(bus.update_o), 64'(exp_upd.pop_front()));
        if (lit_upd.size() != 0) chk("update_lit", 64'(bus.update_o), 64'(lit_upd.pop_front()));
        if (exp_lat != 0)        chk("update_latency", 64'(cyc - acc_cyc), 64'(exp_lat));
      end
      if (bus.fault_valid_o) begin
        if (exp_fault.size() == 0) chk("fault_unexpected", 64'(bus.fault_vaddr_o), 64'(0));
        else                       chk("fault_vaddr", 64'(bus.fault_vaddr_o), 64'(exp_fault.pop_front()));
        if (lit_fault.size() != 0) chk("fault_vaddr_lit", 64'(bus.fault_vaddr_o), 64'(lit_fault.pop_front()));
        if (exp_lat != 0)          chk("fault_latency", 64'(cyc - acc_cyc), 64'(exp_lat));
      end

      if (bus.miss_valid_i && bus.miss_ready_o) acc_cyc = cyc;
      busy_cnt = bus.busy_o ? busy_cnt + 1 : 0;
      if (busy_cnt == 40) chk("busy_bound", 64'(busy_cnt), 64'(0));
      miss_cnt = (bus.miss_valid_i && !bus.miss_ready_o) ? miss_cnt + 1 : 0;
      if (miss_cnt == 20) chk("miss_accept_bound", 64'(miss_cnt), 64'(0));

      p_acc   = bus.miss_valid_i && bus.miss_ready_o;
      p_idle  = !bus.busy_o && !p_acc;
      p_drop  = bus.flush_i && bus.mem_req_valid_o && !bus.mem_req_ready_i;
      p_stall = !bus.flush_i && bus.mem_req_valid_o && !bus.mem_req_ready_i;
      p_addr  = bus.mem_req_addr_o;
      p_drain = bus.mem_rsp_valid_i && outstanding && (flushed || bus.flush_i);
      if (bus.mem_rsp_valid_i) begin
        outstanding = 1'b0;
        flushed     = 1'b0;
      end
      if (bus.flush_i && (outstanding || m_hs)) flushed = 1'b1;
      if (m_hs) outstanding = 1'b1;
    end
    if (done && !fin) begin
      chk("addr_queue_empty", 64'(exp_addr.size()), 64'(0));
      chk("update_queue_empty", 64'(exp_upd.size()), 64'(0));
      chk("fault_queue_empty", 64'(exp_fault.size()), 64'(0));
      fin = 1'b1;
    end
    rst_q = rst;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_miss(logic [31:0] va);
    int n;
    bus.miss_vaddr_i = va;
    bus.miss_asid_i  = 1'b1;
    bus.miss_valid_i = 1'b1;
    n = 0;
    while (!bus.miss_ready_o && n < 25) begin
      tick();
      n++;
    end
    tick();
    bus.miss_valid_i = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (bus.busy_o && n < 60) begin
      tick();
      n++;
    end
    tick();
  endtask

  initial begin
    rst                 = 1'b1;
    bus.flush_i         = 1'b0;
    bus.satp_ppn_i      = 22'h80;
    bus.miss_valid_i    = 1'b0;
    bus.miss_vaddr_i    = 32'h0;
    bus.miss_asid_i     = 1'b0;
    bus.mem_req_ready_i = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // 4K walk with 1-cycle memory
    mem[34'h80004] = 32'h00020401;
    mem[34'h8100C] = 32'h00048CCF;
    model_walk(22'h80, 32'h00403000, 1'b1);
    lit_addr.push_back(34'h80004);
    lit_addr.push_back(34'h8100C);
    lit_upd.push_back({1'b1, 1'b0, 20'h00403, 9'd1, 32'h00048CCF});
    exp_lat = 5;
    run_miss(32'h00403000);
    wait_idle();

    // 4M superpage: no level-0 request
    mem[34'h80004] = 32'h200000CF;
    model_walk(22'h80, 32'h00403000, 1'b1);
    lit_addr.push_back(34'h80004);
    lit_upd.push_back({1'b1, 1'b1, 20'h00403, 9'd1, 32'h200000CF});
    exp_lat = 3;
    run_miss(32'h00403000);
    wait_idle();
    exp_lat = 0;

    // Faults: misaligned superpage, invalid root entry, non-leaf and write-only at level 0
    mem[34'h80004] = 32'h200004CF;
    model_walk(22'h80, 32'h00403000, 1'b1);
    lit_fault.push_back(32'h00403000);
    run_miss(32'h00403000);
    wait_idle();
    mem[34'h80004] = 32'h00000000;
    model_walk(22'h80, 32'h00403000, 1'b1);
    run_miss(32'h00403000);
    wait_idle();
    mem[34'h80004] = 32'h00020401;
    mem[34'h81010] = 32'h00030001;
    mem[34'h81014] = 32'h00012005;
    model_walk(22'h80, 32'h00404000, 1'b1);
    lit_fault.push_back(32'h00404000);
    run_miss(32'h00404000);
    wait_idle();
    model_walk(22'h80, 32'h00405000, 1'b1);
    run_miss(32'h00405000);
    wait_idle();

    // Flush in L1_WAIT, response two cycles later, then a fresh walk
    exp_addr.push_back(34'h80004);
    rsp_lat = 3;
    run_miss(32'h00403000);
    tick();
    bus.flush_i = 1'b1;
    tick();
    bus.flush_i = 1'b0;
    wait_idle();
    rsp_lat = 1;
    model_walk(22'h80, 32'h00403000, 1'b1);
    run_miss(32'h00403000);
    wait_idle();

    // Backpressure for three cycles, then the walk completes
    bus.mem_req_ready_i = 1'b0;
    model_walk(22'h80, 32'h00403000, 1'b1);
    run_miss(32'h00403000);
    repeat (3) tick();
    bus.mem_req_ready_i = 1'b1;
    wait_idle();

    // Backpressure with flush in the second stalled cycle
    bus.mem_req_ready_i = 1'b0;
    run_miss(32'h00403000);
    tick();
    bus.flush_i = 1'b1;
    tick();
    bus.flush_i = 1'b0;
    bus.mem_req_ready_i = 1'b1;
    wait_idle();

    // Miss together with flush in IDLE is refused
    bus.flush_i      = 1'b1;
    bus.miss_vaddr_i = 32'h00403000;
    bus.miss_valid_i = 1'b1;
    repeat (2) tick();
    bus.miss_valid_i = 1'b0;
    bus.flush_i      = 1'b0;
    tick();

    // Reset in L0_WAIT; the late level-0 response must be ignored
    mem[34'h80004] = 32'h00020401;
    exp_addr.push_back(34'h80004);
    exp_addr.push_back(34'h8100C);
    rsp_lat = 2;
    run_miss(32'h00403000);
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (3) tick();
    rsp_lat = 1;
    model_walk(22'h80, 32'h00403000, 1'b1);
    run_miss(32'h00403000);
    wait_idle();

    done = 1'b1;
    for (int n = 0; n < 10 && !fin; n++) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
